// File: rtl/peak_finder_if.sv
`default_nettype none
// ============================================================================
//  Module      : peak_finder_if
//  Description : Pulse-record readout bus of peak_finder. One record per
//                valid/ready handshake.
//                  peak_valid  record available              (master -> slave)
//                  peak_ready  consumer accepts record       (slave  -> master)
//                  peak_amp    signed max sample of pulse    (master -> slave)
//                  peak_time   timestamp of first max sample (master -> slave)
//                  peak_width  samples above threshold       (master -> slave)
//  Revision    : 1.0  initial release
// ============================================================================
interface peak_finder_if #(
    parameter int DATA_W = 16,
    parameter int TS_W   = 16,
    parameter int WID_W  = 7
) ();
    logic                     peak_valid;
    logic                     peak_ready;
    logic signed [DATA_W-1:0] peak_amp;
    logic        [TS_W-1:0]   peak_time;
    logic        [WID_W-1:0]  peak_width;

    modport master (
        output peak_valid, peak_amp, peak_time, peak_width,
        input  peak_ready
    );

    modport slave (
        input  peak_valid, peak_amp, peak_time, peak_width,
        output peak_ready
    );
endinterface
`default_nettype wire

// File: rtl/peak_finder.sv
`default_nettype none
// ============================================================================
//  Module      : peak_finder
//  Description : Finds pulses above a signed threshold in a stream of filtered
//                samples (one per clk). For each pulse, emits the signed peak
//                amplitude, the timestamp of the first peak sample and the
//                pulse width into a 1-entry valid/ready output register, then
//                ignores the input for HOLDOFF cycles.
//  Ports       : clk, reset (sync, active-high)
//                input_data  filtered sample (always valid)
//                threshold   signed arming threshold (latched at arm time)
//                rec         record readout bus (peak_finder_if.master)
//                lost_cnt    saturating count of records dropped on a full
//                            output register
//                pileup_cnt  saturating count of pile-ups seen during holdoff
//  Options     : `define PEAK_FINDER_PILEUP_EN enables pile-up counting;
//                otherwise pileup_cnt is tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module peak_finder #(
    parameter int DATA_W    = 16,
    parameter int TS_W      = 16,
    parameter int HOLDOFF   = 8,
    parameter int MAX_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] input_data,
    input  logic signed [DATA_W-1:0] threshold,
    peak_finder_if.master            rec,
    output logic        [15:0]       lost_cnt,
    output logic        [15:0]       pileup_cnt
);

    localparam int             c_wid_w   = $clog2(MAX_WIDTH + 1);
    localparam [c_wid_w-1:0]   c_max_wid = c_wid_w'(MAX_WIDTH);
    localparam [7:0]           c_holdoff = 8'(HOLDOFF);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;

    logic        [TS_W-1:0]   r_ts;
    logic signed [DATA_W-1:0] r_thr_q;
    logic signed [DATA_W-1:0] r_max;
    logic        [TS_W-1:0]   r_max_ts;
    logic        [c_wid_w-1:0] r_wid;
    logic        [7:0]        r_hold_cnt;

    logic                     r_valid;
    logic signed [DATA_W-1:0] r_amp;
    logic        [TS_W-1:0]   r_time;
    logic        [c_wid_w-1:0] r_width;
    logic        [15:0]       r_lost;

    logic                     w_gt_thr_in;
    logic                     w_gt_q;
    logic                     w_gt_max;
    logic        [c_wid_w-1:0] w_wid_inc;
    logic                     w_emit;
    logic signed [DATA_W-1:0] w_emit_amp;
    logic        [TS_W-1:0]   w_emit_ts;
    logic        [c_wid_w-1:0] w_emit_wid;
    logic                     w_load_ok;

    assign w_gt_thr_in = input_data > threshold;
    assign w_gt_q      = input_data > r_thr_q;
    assign w_gt_max    = input_data > r_max;
    assign w_wid_inc   = r_wid + 1'b1;
    // The output register can take a new record when empty or being drained.
    assign w_load_ok   = !r_valid || rec.peak_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_emit_amp   = r_max;
        w_emit_ts    = r_max_ts;
        w_emit_wid   = r_wid;
        case (r_state)
            S_IDLE: begin
                if (w_gt_thr_in) begin
                    w_next_state = S_TRACK;
                    // Degenerate limit: a single sample already fills the width.
                    if (c_max_wid == c_wid_w'(1)) begin
                        w_emit       = 1'b1;
                        w_emit_amp   = input_data;
                        w_emit_ts    = r_ts;
                        w_emit_wid   = c_max_wid;
                        w_next_state = S_HOLD;
                    end
                end
            end
            S_TRACK: begin
                if (w_gt_q) begin
                    // Strict compare keeps the earliest of equal maxima.
                    if (w_gt_max) begin
                        w_emit_amp = input_data;
                        w_emit_ts  = r_ts;
                    end
                    w_emit_wid = w_wid_inc;
                    if (w_wid_inc == c_max_wid) begin
                        w_emit       = 1'b1;
                        w_next_state = S_HOLD;
                    end
                end else begin
                    w_emit       = 1'b1;
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt <= 8'd1) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Free-running timestamp and pulse-tracking datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts       <= '0;
            r_thr_q    <= '0;
            r_max      <= '0;
            r_max_ts   <= '0;
            r_wid      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_gt_thr_in) begin
                        r_thr_q  <= threshold;
                        r_max    <= input_data;
                        r_max_ts <= r_ts;
                        r_wid    <= c_wid_w'(1);
                    end
                end
                S_TRACK: begin
                    if (w_gt_q) begin
                        r_wid <= w_wid_inc;
                        if (w_gt_max) begin
                            r_max    <= input_data;
                            r_max_ts <= r_ts;
                        end
                    end
                end
                S_HOLD: begin
                    r_hold_cnt <= r_hold_cnt - 1'b1;
                end
                default: begin
                end
            endcase
            if (w_emit) begin
                r_hold_cnt <= c_holdoff;
            end
        end
    end

    // 1-entry output register with drop accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_amp   <= '0;
            r_time  <= '0;
            r_width <= '0;
            r_lost  <= '0;
        end else begin
            if (w_emit && w_load_ok) begin
                r_valid <= 1'b1;
                r_amp   <= w_emit_amp;
                r_time  <= w_emit_ts;
                r_width <= w_emit_wid;
            end else if (r_valid && rec.peak_ready) begin
                r_valid <= 1'b0;
            end
            if (w_emit && !w_load_ok && (r_lost != 16'hFFFF)) begin
                r_lost <= r_lost + 1'b1;
            end
        end
    end

    assign rec.peak_valid = r_valid;
    assign rec.peak_amp   = r_amp;
    assign rec.peak_time  = r_time;
    assign rec.peak_width = r_width;
    assign lost_cnt       = r_lost;

`ifdef PEAK_FINDER_PILEUP_EN
    logic        r_prev_gt;
    logic        r_pile_seen;
    logic [15:0] r_pile_cnt;
    logic        w_cur_gt;

    // The sample that ends a pulse is judged against the latched threshold,
    // so the first holdoff sample sees a consistent "previous" flag.
    assign w_cur_gt = (r_state == S_IDLE) ? w_gt_thr_in : w_gt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_gt   <= 1'b0;
            r_pile_seen <= 1'b0;
            r_pile_cnt  <= '0;
        end else begin
            r_prev_gt <= w_cur_gt;
            if (w_emit) begin
                r_pile_seen <= 1'b0;
            end else if ((r_state == S_HOLD) && w_gt_q && !r_prev_gt && !r_pile_seen) begin
                r_pile_seen <= 1'b1;
                if (r_pile_cnt != 16'hFFFF) begin
                    r_pile_cnt <= r_pile_cnt + 1'b1;
                end
            end
        end
    end

    assign pileup_cnt = r_pile_cnt;
`else
    assign pileup_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_peak_finder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_peak_finder
//  Description : Directed scoreboard bench for peak_finder. Stimulus pushes
//                hand-computed records into a queue; a negedge monitor pops
//                and compares on every output handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_peak_finder;

    typedef struct packed {
        logic signed [15:0] amp;
        logic        [15:0] tm;
        logic        [6:0]  wid;
    } rec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] input_data;
    logic signed [15:0] threshold;
    logic        [15:0] lost_cnt;
    logic        [15:0] pileup_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_rec   = 0;
    int   tb_ts   = 0;
    rec_t exp_q[$];

    peak_finder_if #(.DATA_W(16), .TS_W(16), .WID_W(7)) u_if ();

    peak_finder #(
        .DATA_W    (16),
        .TS_W      (16),
        .HOLDOFF   (8),
        .MAX_WIDTH (64)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .input_data (input_data),
        .threshold  (threshold),
        .rec        (u_if.master),
        .lost_cnt   (lost_cnt),
        .pileup_cnt (pileup_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sample driven now is the one seen at the next rising edge (ts = tb_ts).
    task automatic send(input logic signed [15:0] d);
        input_data = d;
        @(posedge clk);
        #1;
        tb_ts++;
    endtask

    task automatic send_n(input logic signed [15:0] d, input int n);
        for (int i = 0; i < n; i++) send(d);
    endtask

    task automatic expect_rec(input logic signed [15:0] a, input int t, input int w);
        rec_t r;
        r.amp = a;
        r.tm  = 16'(t);
        r.wid = 7'(w);
        exp_q.push_back(r);
    endtask

    // Monitor: a handshake seen at negedge completes at the next rising edge.
    always @(negedge clk) begin
        if (!reset && u_if.peak_valid && u_if.peak_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_record: got amp=%0d time=%0d width=%0d, expected none",
                         u_if.peak_amp, u_if.peak_time, u_if.peak_width);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                n_rec++;
                check($sformatf("rec%0d_amp", n_rec), longint'(u_if.peak_amp), longint'(e.amp));
                check($sformatf("rec%0d_time", n_rec), longint'(u_if.peak_time), longint'(e.tm));
                check($sformatf("rec%0d_width", n_rec), longint'(u_if.peak_width), longint'(e.wid));
            end
        end
    end

    initial begin
        reset           = 1'b1;
        input_data      = '0;
        threshold       = 16'sd100;
        u_if.peak_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tb_ts = 0;

        // Single pulse at ts 10..16.
        send_n(0, 10);
        expect_rec(300, 13, 4);
        send(0); send(50); send(150); send(300); send(250); send(120); send(90);
        check("single_valid_hi", longint'(u_if.peak_valid), 1);
        send(0);
        check("single_valid_lo", longint'(u_if.peak_valid), 0);

        // Backpressure: pulse A kept, pulse B dropped.
        send_n(0, 30 - tb_ts);
        u_if.peak_ready = 1'b0;
        expect_rec(400, 31, 2);
        send(200); send(400); send(50);
        send_n(0, 45 - tb_ts);
        send(150); send(160); send(0);
        check("bp_valid_held", longint'(u_if.peak_valid), 1);
        check("bp_amp_held", longint'(u_if.peak_amp), 400);
        check("bp_time_held", longint'(u_if.peak_time), 31);
        check("bp_width_held", longint'(u_if.peak_width), 2);
        check("bp_lost_cnt", longint'(lost_cnt), 1);
        send(0);
        check("bp_amp_stable", longint'(u_if.peak_amp), 400);
        u_if.peak_ready = 1'b1;
        send(0);
        check("bp_valid_drop", longint'(u_if.peak_valid), 0);

        // Reset in the middle of a pulse: nothing emitted, all outputs cleared.
        send_n(0, 56 - tb_ts);
        send(200); send(200);
        reset = 1'b1;
        send_n(0, 3);
        check("rst_valid", longint'(u_if.peak_valid), 0);
        check("rst_amp", longint'(u_if.peak_amp), 0);
        check("rst_time", longint'(u_if.peak_time), 0);
        check("rst_width", longint'(u_if.peak_width), 0);
        check("rst_lost", longint'(lost_cnt), 0);
        check("rst_pileup", longint'(pileup_cnt), 0);
        reset = 1'b0;
        tb_ts = 0;

        // Tie at ts 20..23; threshold port must be ignored while tracking.
        send_n(0, 20);
        expect_rec(300, 21, 3);
        send(150);
        threshold = 16'sd1000;
        send(300); send(300);
        threshold = 16'sd100;
        send(90);

        // Width limit: constant 500 from ts 32; re-arm exactly 8 cycles later.
        send_n(0, 32 - tb_ts);
        expect_rec(500, 32, 64);
        expect_rec(500, 104, 64);
        send_n(500, 168 - tb_ts);

        // Pile-up during holdoff (two rising crossings, at most one counted).
        send_n(0, 180 - tb_ts);
        expect_rec(200, 180, 1);
        send(200); send(90);
        send(90); send(200); send(50); send(250);
        send_n(0, 190 - tb_ts);
`ifdef PEAK_FINDER_PILEUP_EN
        check("pileup_cnt", longint'(pileup_cnt), 1);
`else
        check("pileup_cnt", longint'(pileup_cnt), 0);
`endif

        // Signed comparisons with a negative threshold.
        send_n(0, 200 - tb_ts);
        threshold = -16'sd50;
        send_n(-100, 4);
        expect_rec(10, 205, 3);
        send(-40); send(10); send(-30); send(-60);
        send_n(-100, 12);

        check("records_seen", longint'(n_rec), 7);
        check("queue_empty", longint'(exp_q.size()), 0);
        check("lost_final", longint'(lost_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
